// File: rtl/u_enc.sv
// Unary (thermometer) encoder with a 2-entry output FIFO, valid/ready on both sides
// and a saturating count of accepted requests.
module u_enc #(
  parameter int P_W                   = 16,
  parameter bit P_ADMIT_COMPLIMENT_EN = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_in_vld,
  input  logic [$clog2(P_W+1)-1:0]   i_in_k,
  input  logic                       i_in_inv,
  output logic                       o_in_rdy,
  output logic                       o_out_vld,
  output logic [P_W-1:0]             o_out_u,
  output logic                       o_out_err,
  input  logic                       i_out_rdy,
  output logic [15:0]                o_acc_cnt
);

  localparam int KW = $clog2(P_W+1);

  // Returns {err, word}; out-of-range counts give a zero word flagged as an error.
  function automatic logic [P_W:0] encode(input logic [KW-1:0] k, input logic inv);
    logic [P_W-1:0] word;
    logic           err;
    word = '0;
    err  = 1'b0;
    if (int'(k) > P_W) begin
      err = 1'b1;
    end else begin
      for (int i = 0; i < P_W; i++) word[i] = (i < int'(k));
      if (inv) begin
        if (P_ADMIT_COMPLIMENT_EN) word = ~word;
        else                       err  = 1'b1;
      end
    end
    return {err, word};
  endfunction

  logic [P_W-1:0] mem_u_p0 [2];
  logic [1:0]     mem_err_p0;
  logic           wr_ptr;
  logic           rd_ptr;
  logic [1:0]     occ;
  logic           rdy;
  logic [15:0]    acc_cnt;

  logic           acc;
  logic           rel;
  logic [1:0]     occ_nxt;
  logic [P_W:0]   enc_w;

  always_comb begin
    acc     = i_in_vld & rdy;
    rel     = (occ != 2'd0) & i_out_rdy;
    occ_nxt = occ;
    if (acc & ~rel)      occ_nxt = occ + 2'd1;
    else if (~acc & rel) occ_nxt = occ - 2'd1;
    enc_w   = encode(i_in_k, i_in_inv);
  end

  // Stage p0: encoded words land in the FIFO slot addressed by the write pointer
  always_ff @(posedge clk) begin
    if (acc) begin
      mem_u_p0[wr_ptr]   <= enc_w[P_W-1:0];
      mem_err_p0[wr_ptr] <= enc_w[P_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ     <= 2'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      rdy     <= 1'b1;
      acc_cnt <= 16'd0;
    end else begin
      occ <= occ_nxt;
      rdy <= (occ_nxt < 2'd2);
      if (acc) begin
        wr_ptr <= ~wr_ptr;
        if (acc_cnt != 16'hFFFF) acc_cnt <= acc_cnt + 16'd1;
      end
      if (rel) rd_ptr <= ~rd_ptr;
    end
  end

  // Empty FIFO presents zeros so stale or uninitialised slots never leak out.
  assign o_out_vld = (occ != 2'd0);
  assign o_out_u   = o_out_vld ? mem_u_p0[rd_ptr] : '0;
  assign o_out_err = o_out_vld ? mem_err_p0[rd_ptr] : 1'b0;
  assign o_in_rdy  = rdy;
  assign o_acc_cnt = acc_cnt;

endmodule

// File: doc/u_enc.md
U_ENC -- requirements
Module: u_enc

Interface
REQ-001 P_W, 16, width of the unary output vector; legal range 2..64.
REQ-002 P_ADMIT_COMPLIMENT_EN, 0, when 1 a complemented unary code may be emitted; when 0 only true unary is emitted.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 i_in_vld  input  1  input request valid.
REQ-006 i_in_k  input  $clog2(P_W+1)  binary count of ones to encode.
REQ-007 i_in_inv  input  1  request the complemented code.
REQ-008 o_in_rdy  output  1  the block can accept a request; driven directly from a flop.
REQ-009 o_out_vld  output  1  output word valid.
REQ-010 o_out_u  output  P_W  encoded unary word.
REQ-011 o_out_err  output  1  the output word came from an illegal request.
REQ-012 i_out_rdy  input  1  downstream accepts the output word.
REQ-013 o_acc_cnt  output  16  saturating count of accepted requests.

Function
REQ-014 The block SHALL accept a request on a cycle where i_in_vld & o_in_rdy, and SHALL accept nothing on any other cycle.
REQ-015 The block SHALL release an output word on a cycle where o_out_vld & i_out_rdy.
REQ-016 Encoding: for k in 0..P_W, o_out_u[i] SHALL be 1 for i<k and 0 otherwise (ones fill from the LSB; k=0 gives all zeros, k=P_W gives all ones).
REQ-017 If i_in_inv=1 and P_ADMIT_COMPLIMENT_EN=1, the block SHALL emit the bitwise inverse of the REQ-016 word with o_out_err=0.
REQ-018 If i_in_inv=1 and P_ADMIT_COMPLIMENT_EN=0, the block SHALL emit the uncomplemented REQ-016 word with o_out_err=1.
REQ-019 If i_in_k>P_W, the block SHALL emit o_out_u=0 with o_out_err=1, regardless of i_in_inv.
REQ-020 Latency: an accepted request SHALL appear on o_out_* on the following cycle when the buffer is empty, i.e. one cycle of latency.
REQ-021 Buffering: a 2-entry FIFO SHALL hold the encoded words, the err flag, and the order of acceptance; o_out_* SHALL always present the oldest entry.
REQ-022 o_in_rdy SHALL be registered and SHALL equal 1 when the occupancy after the current cycle's update is less than 2.
REQ-023 Throughput: with i_out_rdy held at 1, the block SHALL sustain one accept and one release per cycle with no bubbles.
REQ-024 Simultaneous accept and release at occupancy 1 SHALL leave the occupancy at 1, and the new word SHALL become head on the next cycle.
REQ-025 Simultaneous accept and release at occupancy 2 cannot occur, because o_in_rdy=0 at occupancy 2.
REQ-026 Full: at occupancy 2, i_in_vld SHALL be ignored and the stored words SHALL remain stable until released.
REQ-027 Empty: at occupancy 0, o_out_vld SHALL be 0; o_out_u and o_out_err are don't-care but SHALL NOT be X.
REQ-028 While o_out_vld=1 and i_out_rdy=0, o_out_u and o_out_err SHALL hold constant.
REQ-029 FIFO read and write pointers SHALL be 1 bit each and SHALL wrap modulo 2.
REQ-030 o_acc_cnt SHALL increment by 1 per accept and SHALL saturate at 16'hFFFF.

Reset
REQ-031 On rst=1 at a clock edge, the block SHALL set occupancy=0, both pointers=0, o_out_vld=0, o_in_rdy=1, o_out_u=0, o_out_err=0, and o_acc_cnt=0.
REQ-032 Reset asserted mid-operation SHALL discard all buffered words, and no word accepted or buffered before the reset SHALL appear afterwards.
REQ-033 While rst=1, o_in_rdy SHALL read 1 on the cycle after the first reset edge, and the block SHALL accept nothing during reset.

Verification
REQ-034 P_W=16: k=5 with i_out_rdy=1 -> the next cycle shows o_out_vld=1, o_out_u=16'h001F, o_out_err=0; k=0 -> 16'h0000; k=16 -> 16'hFFFF.
REQ-035 P_W=16, P_ADMIT_COMPLIMENT_EN=1: k=3 with inv=1 -> o_out_u=16'hFFF8, o_out_err=0; with P_ADMIT_COMPLIMENT_EN=0 the same request -> 16'h0007, o_out_err=1.
REQ-036 P_W=16: k=17 -> o_out_u=16'h0000, o_out_err=1.
REQ-037 Backpressure: i_out_rdy=0 and requests k=1,2,3 on consecutive cycles -> the first two are accepted and o_in_rdy=0; after raising i_out_rdy, words 0x0001 then 0x0003 are released and k=3 is accepted afterwards, giving o_acc_cnt=3.
REQ-038 Streaming: 100 back-to-back requests with i_out_rdy=1 -> 100 words released in order on consecutive cycles, with o_acc_cnt=100.
REQ-039 Reset at occupancy 2 -> the next cycle shows o_out_vld=0, o_in_rdy=1, o_acc_cnt=0, and neither pre-reset word is ever released.
